// File: rtl/data_mem.sv
// Data memory stage: word/half/byte loads and stores
// with address error flags and a store trace.
module data_mem #(
  parameter int DEPTH_WORDS = 3072,
  parameter int IDX_W       = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opDM,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  output logic [31:0] RD,
  output logic        AdEL,
  output logic        AdES
);

  localparam logic [3:0] OP_LW  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LHU = 4'b0011;
  localparam logic [3:0] OP_LB  = 4'b0100;
  localparam logic [3:0] OP_LBU = 4'b0101;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SB  = 4'b1011;

  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

  logic [31:0] mem [DEPTH_WORDS];

  logic isLw, isLh, isLhu, isLb, isLbu;
  logic isSw, isSh, isSb;
  logic isLoad, isStore;
  logic misAlign, outRange, badAddr;
  logic wrEn;

  logic [IDX_W-1:0] idx;
  logic [31:0]      curWord;
  logic [31:0]      newWord;
  logic [15:0]      halfV;
  logic [7:0]       byteV;
  logic [31:0]      rdData;

  assign isLw  = (opDM == OP_LW);
  assign isLh  = (opDM == OP_LH);
  assign isLhu = (opDM == OP_LHU);
  assign isLb  = (opDM == OP_LB);
  assign isLbu = (opDM == OP_LBU);
  assign isSw  = (opDM == OP_SW);
  assign isSh  = (opDM == OP_SH);
  assign isSb  = (opDM == OP_SB);

  assign isLoad  = isLw | isLh | isLhu | isLb | isLbu;
  assign isStore = isSw | isSh | isSb;

  assign misAlign =
    ((isLw | isSw) & (Addr[1:0] != 2'b00)) |
    ((isLh | isLhu | isSh) & Addr[0]);

  // Full-width compare so high addresses never alias low words
  assign outRange = (Addr >= LIMIT);
  assign badAddr  = misAlign | outRange;

  assign AdEL = isLoad & badAddr;
  assign AdES = isStore & badAddr;
  assign wrEn = isStore & ~badAddr;

  assign idx     = Addr[IDX_W+1:2];
  assign curWord = outRange ? '0 : mem[idx];

  assign halfV = Addr[1] ? curWord[31:16] : curWord[15:0];
  assign byteV = curWord[{Addr[1:0], 3'b000} +: 8];

  // Load extraction and extension
  always_comb begin
    rdData = '0;
    unique case (1'b1)
      isLw:  rdData = curWord;
      isLh:  rdData = {{16{halfV[15]}}, halfV};
      isLhu: rdData = {16'h0000, halfV};
      isLb:  rdData = {{24{byteV[7]}}, byteV};
      isLbu: rdData = {24'h000000, byteV};
      default: rdData = '0;
    endcase
  end

  assign RD = (isLoad & ~badAddr) ? rdData : '0;

  // Merge store data into the addressed word lanes
  always_comb begin
    newWord = curWord;
    unique case (1'b1)
      isSw: newWord = WD;
      isSh: newWord[{Addr[1], 4'b0000} +: 16] = WD[15:0];
      isSb: newWord[{Addr[1:0], 3'b000} +: 8] = WD[7:0];
      default: newWord = curWord;
    endcase
  end

  // Storage: async clear, otherwise commit legal stores
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[idx] <= newWord;
    end
  end

`ifndef SYNTHESIS
  // Trace each committed store with its merged word
  always @(posedge clk) begin
    if (reset && wrEn) begin
      $display("@%h: *%h <= %h", PC,
               {Addr[31:2], 2'b00}, newWord);
    end
  end
`endif

endmodule

// File: tb/tb_data_mem.sv
// Randomized and directed checks of data_mem
// against a byte-addressed reference model.
module tb_data_mem;

  localparam int NBYTES = 3072 * 4;

  localparam logic [3:0] LW  = 4'b0001;
  localparam logic [3:0] LH  = 4'b0010;
  localparam logic [3:0] LHU = 4'b0011;
  localparam logic [3:0] LB  = 4'b0100;
  localparam logic [3:0] LBU = 4'b0101;
  localparam logic [3:0] SW  = 4'b1001;
  localparam logic [3:0] SH  = 4'b1010;
  localparam logic [3:0] SB  = 4'b1011;

  logic        clk;
  logic        reset;
  logic [3:0]  opDM;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] PC;
  logic [31:0] RD;
  logic        AdEL;
  logic        AdES;

  logic [7:0] bytes [NBYTES];
  int passes;
  int total;
  logic [31:0] pcCnt;

  data_mem dut (
    .clk  (clk),
    .reset(reset),
    .opDM (opDM),
    .Addr (Addr),
    .WD   (WD),
    .PC   (PC),
    .RD   (RD),
    .AdEL (AdEL),
    .AdES (AdES)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic clearModel();
    for (int i = 0; i < NBYTES; i++) bytes[i] = 8'h00;
  endtask

  // Reference: access size, legality, load value, store effect
  task automatic model(input logic [3:0] op,
                       input logic [31:0] a,
                       output logic [31:0] eRd,
                       output logic eL, output logic eS,
                       output bit commit);
    int sz;
    bit ld, st, sgn, bad;
    logic [63:0] v;
    ld  = (op >= 4'd1 && op <= 4'd5);
    st  = (op >= 4'd9 && op <= 4'd11);
    sgn = (op == LH || op == LB);
    if (op == LW || op == SW) sz = 4;
    else if (op == LH || op == LHU || op == SH) sz = 2;
    else sz = 1;
    bad = ((a % sz) != 0) || (a >= 32'(NBYTES));
    eL = ld && bad;
    eS = st && bad;
    commit = st && !bad;
    eRd = '0;
    if (ld && !bad) begin
      v = 0;
      for (int k = 0; k < sz; k++)
        v = v + (64'(bytes[a + k]) << (8 * k));
      if (sgn && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
      eRd = v[31:0];
    end
  endtask

  task automatic step(input logic [3:0] op,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input string tag);
    logic [31:0] eRd;
    logic eL, eS;
    bit commit;
    @(negedge clk);
    opDM = op; Addr = a; WD = d; PC = pcCnt;
    pcCnt = pcCnt + 4;
    #1;
    model(op, a, eRd, eL, eS, commit);
    chk({tag, ".rd"}, RD, eRd);
    chk({tag, ".adel"}, 32'(AdEL), 32'(eL));
    chk({tag, ".ades"}, 32'(AdES), 32'(eS));
    @(posedge clk);
    if (commit && reset === 1'b1) begin
      int sz;
      sz = (op == SW) ? 4 : (op == SH) ? 2 : 1;
      for (int k = 0; k < sz; k++)
        bytes[a + k] = d[8*k +: 8];
    end
    #1;
  endtask

  // Load with an additional fixed expected value
  task automatic ldv(input logic [3:0] op,
                     input logic [31:0] a,
                     input logic [31:0] want,
                     input string tag);
    step(op, a, 32'h0, tag);
    chk({tag, ".fix"}, RD, want);
  endtask

  logic [3:0] ops [16];

  initial begin
    passes = 0;
    total  = 0;
    pcCnt  = 32'h0000_3000;
    reset  = 1'b0;
    opDM   = 4'h0;
    Addr   = '0;
    WD     = '0;
    PC     = '0;
    clearModel();
    #12;
    reset = 1'b1;

    #1;
    chk("rst.rd", RD, 32'h0);
    chk("rst.adel", 32'(AdEL), 32'h0);
    chk("rst.ades", 32'(AdES), 32'h0);
    ldv(LW, 32'h0000, 32'h0, "rst.lw0");
    ldv(LW, 32'h2FFC, 32'h0, "rst.lwtop");

    step(SW, 32'h10, 32'h12345678, "sw10");
    ldv(LB, 32'h13, 32'h00000012, "lb13");
    ldv(LH, 32'h12, 32'h00001234, "lh12");
    ldv(LBU, 32'h10, 32'h00000078, "lbu10");

    step(SB, 32'h11, 32'hFFFFFF80, "sb11");
    ldv(LW, 32'h10, 32'h12348078, "lw10a");
    ldv(LB, 32'h11, 32'hFFFFFF80, "lb11");
    ldv(LBU, 32'h11, 32'h00000080, "lbu11");
    step(SH, 32'h12, 32'h0000ABCD, "sh12");
    ldv(LW, 32'h10, 32'hABCD8078, "lw10b");
    ldv(LH, 32'h12, 32'hFFFFABCD, "lh12b");
    ldv(LHU, 32'h12, 32'h0000ABCD, "lhu12");

    step(SW, 32'h20, 32'h01020304, "sw20");
    step(SW, 32'h22, 32'hCAFEF00D, "sw22bad");
    ldv(LW, 32'h20, 32'h01020304, "lw20");
    step(LH, 32'h21, 32'h0, "lh21bad");
    step(SB, 32'h23, 32'h000000EE, "sb23");
    ldv(LW, 32'h20, 32'hEE020304, "lw20b");

    step(SW, 32'h3000, 32'h55555555, "sw3000");
    step(LW, 32'h3000, 32'h0, "lw3000");
    step(LW, 32'hFFFFFFFC, 32'h0, "lwwrap");
    ldv(LW, 32'h0FFC, 32'h0, "lw0ffc");

    // Reset pulled low mid-cycle under a pending store
    @(negedge clk);
    opDM = SW; Addr = 32'h40; WD = 32'hDEADBEEF;
    #2;
    reset = 1'b0;
    clearModel();
    #1;
    chk("rstmid.rd", RD, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    opDM = LW; Addr = 32'h10;
    #1;
    chk("rstclr.lw10", RD, 32'h0);
    reset = 1'b1;
    #1;
    ldv(LW, 32'h40, 32'h0, "rst.lw40");
    step(SW, 32'h40, 32'hDEADBEEF, "sw40");
    ldv(LW, 32'h40, 32'hDEADBEEF, "lw40");

    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9,
            4'd10, 4'd11, 4'd9, 4'd10, 4'd11, 4'd6,
            4'd8, 4'd12, 4'd15};
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 6) a = 32'($urandom_range(0, 255));
      else if (r < 8) a = 32'h2FF0 + 32'($urandom_range(0, 31));
      else a = $urandom;
      step(ops[$urandom_range(0, 15)], a, $urandom, "rnd");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
